// File: rtl/sprint1_pkg.sv
// rtl/sprint1_pkg.sv - shared FSM state codes and ROM region constants
package sprint1_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_LOAD   = 3'd1;
  localparam state_t ST_SETTLE = 3'd2;
  localparam state_t ST_RUN    = 3'd3;
  localparam state_t ST_FAULT  = 3'd4;

  localparam logic [2:0] SEL_PROG = 3'b001;
  localparam logic [2:0] SEL_GFX  = 3'b010;
  localparam logic [2:0] SEL_PROM = 3'b100;

  localparam logic [16:0] CNT_MAX = 17'h1FFFF;

  function automatic logic [16:0] sat_inc(input logic [16:0] v);
    return (v == CNT_MAX) ? v : v + 17'd1;
  endfunction

endpackage

// File: rtl/rom_region_dec.sv
// rtl/rom_region_dec.sv - combinational byte address to one-hot ROM region select
module rom_region_dec
  import sprint1_pkg::*;
#(
  parameter logic [16:0] PROG_END = 17'h01FFF,
  parameter logic [16:0] GFX_END  = 17'h02FFF
) (
  input  logic [16:0] i_addr,
  output logic [2:0]  o_sel
);

  always_comb begin
    o_sel = SEL_PROM;
    if (i_addr <= PROG_END)
      o_sel = SEL_PROG;
    else if (i_addr <= GFX_END)
      o_sel = SEL_GFX;
  end

endmodule

// File: rtl/rom_load_seq.sv
// rtl/rom_load_seq.sv - HPS ROM download sequencer: forwards bytes, validates image, sequences core reset
module rom_load_seq
  import sprint1_pkg::*;
#(
  parameter logic [16:0] EXPECT_BYTES  = 17'd12288,
  parameter logic [16:0] PROG_END      = 17'h01FFF,
  parameter logic [16:0] GFX_END       = 17'h02FFF,
  parameter logic [15:0] SETTLE_CYCLES = 16'd1024
) (
  input  logic        clk_sys,
  input  logic        Reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic [16:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        dn_wr,
  output logic [2:0]  rom_sel,
  output logic        core_reset_n,
  output logic        load_done,
  output logic        load_err
);

  state_t      r_state;
  logic [16:0] r_cnt;
  logic        r_err;
  logic [15:0] r_settle;
  logic [16:0] r_dn_addr;
  logic [7:0]  r_dn_data;
  logic        r_dn_wr;
  logic [2:0]  r_rom_sel;

  logic        w_strobe;
  logic        w_in_range;
  logic [16:0] w_cnt_next;
  logic        w_err_next;
  logic [2:0]  w_sel;

  rom_region_dec #(
    .PROG_END (PROG_END),
    .GFX_END  (GFX_END)
  ) u_region_dec (
    .i_addr (ioctl_addr[16:0]),
    .o_sel  (w_sel)
  );

  // The strobe coinciding with the download falling edge must be folded into the compare.
  assign w_strobe   = ioctl_wr && (r_state == ST_LOAD);
  assign w_in_range = (ioctl_addr[24:17] == 8'd0);
  assign w_cnt_next = w_strobe ? sat_inc(r_cnt) : r_cnt;
  assign w_err_next = r_err | (w_strobe & ~w_in_range);

  always_ff @(posedge clk_sys) begin
    if (!Reset_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 17'd0;
      r_err     <= 1'b0;
      r_settle  <= 16'd0;
      r_dn_addr <= 17'd0;
      r_dn_data <= 8'd0;
      r_dn_wr   <= 1'b0;
      r_rom_sel <= SEL_PROG;
    end else begin
      r_dn_wr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (ioctl_download) begin
            r_state  <= ST_LOAD;
            r_cnt    <= 17'd0;
            r_err    <= 1'b0;
            r_settle <= 16'd0;
          end
        end
        ST_LOAD: begin
          r_cnt <= w_cnt_next;
          r_err <= w_err_next;
          if (w_strobe && w_in_range) begin
            r_dn_wr   <= 1'b1;
            r_dn_addr <= ioctl_addr[16:0];
            r_dn_data <= ioctl_dout;
            r_rom_sel <= w_sel;
          end
          if (!ioctl_download) begin
            r_settle <= 16'd0;
            r_state  <= ((w_cnt_next == EXPECT_BYTES) && !w_err_next) ? ST_SETTLE : ST_FAULT;
          end
        end
        ST_SETTLE, ST_RUN, ST_FAULT: begin
          if (ioctl_download) begin
            r_state  <= ST_LOAD;
            r_cnt    <= 17'd0;
            r_err    <= 1'b0;
            r_settle <= 16'd0;
          end else if (r_state == ST_SETTLE) begin
            if (r_settle == SETTLE_CYCLES - 16'd1)
              r_state <= ST_RUN;
            else
              r_settle <= r_settle + 16'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign dn_addr      = r_dn_addr;
  assign dn_data      = r_dn_data;
  assign dn_wr        = r_dn_wr;
  assign rom_sel      = r_rom_sel;
  assign core_reset_n = (r_state == ST_RUN);
  assign load_done    = (r_state == ST_RUN);
  assign load_err     = (r_state == ST_FAULT);

endmodule

// File: tb/tb_rom_load_seq.sv
// tb/tb_rom_load_seq.sv - self-checking bench for rom_load_seq
module tb_rom_load_seq;

  logic        clk_sys;
  logic        Reset_n;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [16:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic [2:0]  rom_sel;
  logic        core_reset_n;
  logic        load_done;
  logic        load_err;

  int n_checks;
  int n_fail;
  int n_pulses;
  int n_pulse_err;
  int n_core_hi;
  int settle_len;

  logic        pend;
  logic [16:0] pend_addr;
  logic [7:0]  pend_data;

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  data;
    logic        exp_wr;
    logic [2:0]  exp_sel;
  } vec_t;

  vec_t vecs[8];

  rom_load_seq dut (
    .clk_sys        (clk_sys),
    .Reset_n        (Reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .dn_addr        (dn_addr),
    .dn_data        (dn_data),
    .dn_wr          (dn_wr),
    .rom_sel        (rom_sel),
    .core_reset_n   (core_reset_n),
    .load_done      (load_done),
    .load_err       (load_err)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Advance one edge, then compare the write port against the pending-write model.
  task automatic tick();
    @(posedge clk_sys);
    #1;
    if (dn_wr === 1'b1) n_pulses++;
    if (dn_wr !== pend)
      n_pulse_err++;
    else if (pend && ((dn_addr !== pend_addr) || (dn_data !== pend_data)))
      n_pulse_err++;
    if (core_reset_n === 1'b1) n_core_hi++;
    pend     = 1'b0;
    ioctl_wr = 1'b0;
  endtask

  task automatic drive(input logic [24:0] a, input logic [7:0] d, input logic exp_wr);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    pend       = exp_wr;
    pend_addr  = a[16:0];
    pend_data  = d;
  endtask

  task automatic run_load(input int n, input int bad_idx, input bit drop);
    ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      logic [24:0] a;
      a = (i == bad_idx) ? 25'h0020000 : 25'(i);
      if (drop && (i == n - 1)) ioctl_download = 1'b0;
      drive(a, 8'(i) ^ 8'h5A, i != bad_idx);
      tick();
    end
  endtask

  task automatic wait_run(output int k);
    k = 0;
    for (int j = 1; j <= 2000; j++) begin
      tick();
      if (core_reset_n === 1'b1) begin
        k = j;
        break;
      end
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dn_wr"},   32'(dn_wr),        32'd0);
    chk({tag, "_dn_addr"}, 32'(dn_addr),      32'd0);
    chk({tag, "_dn_data"}, 32'(dn_data),      32'd0);
    chk({tag, "_rom_sel"}, 32'(rom_sel),      32'd1);
    chk({tag, "_core_rn"}, 32'(core_reset_n), 32'd0);
    chk({tag, "_done"},    32'(load_done),    32'd0);
    chk({tag, "_err"},     32'(load_err),     32'd0);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; n_pulses = 0; n_pulse_err = 0; n_core_hi = 0;
    pend = 1'b0; pend_addr = 17'd0; pend_data = 8'd0;
    Reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    ioctl_addr = 25'd0; ioctl_dout = 8'd0;

    vecs[0] = '{25'h0000000, 8'h11, 1'b1, 3'b001};
    vecs[1] = '{25'h0001FFF, 8'h22, 1'b1, 3'b001};
    vecs[2] = '{25'h0002000, 8'h33, 1'b1, 3'b010};
    vecs[3] = '{25'h0002FFF, 8'h44, 1'b1, 3'b010};
    vecs[4] = '{25'h0003000, 8'h55, 1'b1, 3'b100};
    vecs[5] = '{25'h001FFFF, 8'h66, 1'b1, 3'b100};
    vecs[6] = '{25'h0020000, 8'h77, 1'b0, 3'b100};
    vecs[7] = '{25'h1FFFFFF, 8'h88, 1'b0, 3'b100};

    repeat (3) tick();
    chk_reset_outputs("reset");
    Reset_n = 1'b1;
    tick();

    // Region decode table; out-of-range rows must neither write nor disturb rom_sel.
    ioctl_download = 1'b1;
    tick();
    for (int v = 0; v < 8; v++) begin
      drive(vecs[v].addr, vecs[v].data, vecs[v].exp_wr);
      tick();
      chk($sformatf("vec%0d_dn_wr", v), 32'(dn_wr), 32'(vecs[v].exp_wr));
      chk($sformatf("vec%0d_rom_sel", v), 32'(rom_sel), 32'(vecs[v].exp_sel));
      if (vecs[v].exp_wr) begin
        chk($sformatf("vec%0d_dn_addr", v), 32'(dn_addr), 32'(vecs[v].addr[16:0]));
        chk($sformatf("vec%0d_dn_data", v), 32'(dn_data), 32'(vecs[v].data));
      end
    end
    ioctl_download = 1'b0;
    tick();
    chk("table_fault_err", 32'(load_err), 32'd1);
    chk("table_fault_core", 32'(core_reset_n), 32'd0);
    tick();
    chk("fault_no_wr", 32'(dn_wr), 32'd0);

    n_pulses = 0; n_pulse_err = 0;
    run_load(12287, -1, 1);
    chk("short_pulses", 32'(n_pulses), 32'd12287);
    chk("short_pulse_err", 32'(n_pulse_err), 32'd0);
    chk("short_err", 32'(load_err), 32'd1);
    repeat (20) tick();
    chk("short_core", 32'(core_reset_n), 32'd0);

    n_pulses = 0; n_pulse_err = 0;
    run_load(12288, 5000, 1);
    chk("badaddr_pulses", 32'(n_pulses), 32'd12287);
    chk("badaddr_pulse_err", 32'(n_pulse_err), 32'd0);
    chk("badaddr_err", 32'(load_err), 32'd1);

    // Valid load, then abort it in the 500th settle cycle with a fresh download.
    n_pulses = 0; n_pulse_err = 0; n_core_hi = 0;
    run_load(12288, -1, 1);
    chk("valid1_pulses", 32'(n_pulses), 32'd12288);
    chk("valid1_err_clear", 32'(load_err), 32'd0);
    repeat (499) tick();
    n_pulses = 0;
    run_load(12288, -1, 1);
    chk("abort_core_low", 32'(n_core_hi), 32'd0);
    chk("valid2_pulses", 32'(n_pulses), 32'd12288);
    chk("valid2_pulse_err", 32'(n_pulse_err), 32'd0);
    wait_run(settle_len);
    chk("settle_len", 32'(settle_len), 32'd1024);
    chk("run_done", 32'(load_done), 32'd1);
    chk("run_err", 32'(load_err), 32'd0);
    n_pulses = 0;
    repeat (5) tick();
    chk("run_no_wr", 32'(n_pulses), 32'd0);
    chk("run_stays", 32'(core_reset_n), 32'd1);

    // Reset mid-load with a strobe pending on the same edge.
    n_pulse_err = 0;
    run_load(100, -1, 0);
    drive(25'd100, 8'hEE, 1'b0);
    Reset_n = 1'b0;
    tick();
    chk_reset_outputs("midrst");
    Reset_n = 1'b1;
    ioctl_download = 1'b0;
    n_pulses = 0;
    repeat (4) tick();
    chk("midrst_no_wr", 32'(n_pulses), 32'd0);
    chk("midrst_pulse_err", 32'(n_pulse_err), 32'd0);
    chk("midrst_idle_done", 32'(load_done), 32'd0);
    chk("midrst_idle_err", 32'(load_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
